// File: rtl/alu_issue_scheduler_pkg.sv
// Shared backend package for the ALU issue path.
// Contents:
//   instr_opcode  - backend opcode encoding. NOP_I is 0, so an all-zero issue
//                   register makes the ALU produce its default output of 0.
//   alu_issue_t   - one latched ALU operation {opcode, val1, val2, tag}.
//   sched_state_t - issue scheduler FSM states.
//   cnt_width()   - width of the multiply countdown for a given latency.
package alu_issue_scheduler_pkg;

  typedef enum logic [3:0] {
    NOP_I = 4'd0,
    ADD_I,
    SUB_I,
    AND_I,
    OR_I,
    XOR_I,
    SLL_I,
    SRL_I,
    SLT_I,
    MUL_I,
    BEQ_I,
    BNE_I,
    BLT_I
  } instr_opcode;

  // The tag field is sized for the widest tag any backend uses. Narrower
  // tags are zero-extended on entry and truncated again on exit.
  localparam int ISSUE_TAG_W = 16;

  typedef struct packed {
    instr_opcode             opcode;
    logic [31:0]             val1;
    logic [31:0]             val2;
    logic [ISSUE_TAG_W-1:0]  tag;
  } alu_issue_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    MUL_WAIT = 2'd2
  } sched_state_t;

  // Countdown width: $clog2(lat), never less than one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/alu_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter.
// The winner is the first asserted request at or after the internal pointer,
// searching modulo N. The pointer moves to winner+1 (wrapping) whenever a
// grant is actually issued (en & |req), so a requester that just won has the
// lowest priority on the next arbitration.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pointer -> 0)
//   req [N]   - request vector
//   en        - grant permitted this cycle
//   gnt [N]   - one-hot grant, all zero when !en or no request
module alu_issue_scheduler_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] idx_c;
  logic             found;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx_c   = '0;
    for (int i = 0; i < N; i++) begin
      idx_c = PTR_W'((int'(ptr_reg) + i) % N);
      if (!found && req[idx_c]) begin
        found   = 1'b1;
        win_idx = idx_c;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && found) begin
      gnt[win_idx] = 1'b1;
    end
  end

  assign ptr_next = (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (en && found) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// ALU issue scheduler.
// Arbitrates the shared combinational ALU among NUM_REQ reservation-station
// ports, latches the granted operation into an issue register that drives
// the ALU, holds MUL_I for MUL_LAT cycles, and captures the result (data,
// branch condition, tag) into an output register with a valid/ready
// handshake toward writeback.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - squash issue and output registers (pointer kept)
//   req_*           - per-requester valid/opcode/operands/tag
//   req_ready       - one-hot grant (or zero)
//   alu_opcode/val* - ALU inputs, zero while idle
//   alu_result/br   - ALU outputs
//   res_*           - registered result with valid/ready handshake
//   busy            - issue register occupied
module alu_issue_scheduler
  import alu_issue_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  input  instr_opcode        req_opcode [NUM_REQ],
  input  logic [31:0]        req_val1   [NUM_REQ],
  input  logic [31:0]        req_val2   [NUM_REQ],
  input  logic [TAG_W-1:0]   req_tag    [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output instr_opcode        alu_opcode,
  output logic [31:0]        alu_val1,
  output logic [31:0]        alu_val2,
  input  logic [31:0]        alu_result,
  input  logic               alu_br_cond,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic               res_br_cond,
  output logic [TAG_W-1:0]   res_tag,
  output logic               busy
);

  localparam int          CNT_W     = cnt_width(MUL_LAT);
  localparam bit          MUL_MULTI = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  sched_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  alu_issue_t       iss_reg, iss_next;
  alu_issue_t       iss_grant;
  alu_issue_t       req_issue [NUM_REQ];

  logic             res_valid_reg;
  logic [31:0]      res_data_reg;
  logic             res_br_cond_reg;
  logic [TAG_W-1:0] res_tag_reg;

  logic             out_take;
  logic             is_mul;
  logic             iss_done;
  logic             grant_en;
  logic             granted;
  logic [NUM_REQ-1:0] gnt;

  // Pack each requester's fields into the shared issue format.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_issue[gi] = '{
      opcode: req_opcode[gi],
      val1:   req_val1[gi],
      val2:   req_val2[gi],
      tag:    ISSUE_TAG_W'(req_tag[gi])
    };
  end

  assign out_take = !res_valid_reg || res_ready;
  assign is_mul   = (iss_reg.opcode == MUL_I);

  // The issue register retires when its result can be written to the
  // output register: immediately for single-cycle ops, after the countdown
  // for multiplies.
  assign iss_done = ((state_reg == EXEC) && (!is_mul || !MUL_MULTI) && out_take)
                 || ((state_reg == MUL_WAIT) && (cnt_reg == '0) && out_take);

  // Retiring and granting in the same cycle keeps back-to-back ops bubble-free.
  assign grant_en = !rst && !flush && ((state_reg == IDLE) || iss_done);

  alu_issue_scheduler_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (grant_en),
    .gnt (gnt)
  );

  assign granted   = |gnt;
  assign req_ready = gnt;

  // One-hot select of the granted request.
  always_comb begin
    iss_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        iss_grant = req_issue[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    iss_next   = iss_reg;
    unique case (state_reg)
      IDLE: begin
        if (granted) state_next = EXEC;
      end
      EXEC: begin
        if (is_mul && MUL_MULTI) begin
          state_next = MUL_WAIT;
          cnt_next   = CNT_LOAD;
        end else if (iss_done) begin
          state_next = granted ? EXEC : IDLE;
        end
      end
      MUL_WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else if (iss_done) begin
          state_next = granted ? EXEC : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Clearing the issue register on retirement keeps the ALU inputs at zero.
    if (granted) begin
      iss_next = iss_grant;
    end else if (iss_done) begin
      iss_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      iss_reg         <= '0;
      res_valid_reg   <= 1'b0;
      res_data_reg    <= '0;
      res_br_cond_reg <= 1'b0;
      res_tag_reg     <= '0;
    end else if (flush) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      iss_reg       <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      iss_reg   <= iss_next;
      if (iss_done) begin
        res_valid_reg   <= 1'b1;
        res_data_reg    <= alu_result;
        res_br_cond_reg <= alu_br_cond;
        res_tag_reg     <= iss_reg.tag[TAG_W-1:0];
      end else if (res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  // Upper tag bits beyond TAG_W are always zero.
  logic unused_tag_bits;
  assign unused_tag_bits = ^iss_reg.tag;

  assign busy        = (state_reg != IDLE);
  assign alu_opcode  = busy ? iss_reg.opcode : NOP_I;
  assign alu_val1    = busy ? iss_reg.val1 : 32'd0;
  assign alu_val2    = busy ? iss_reg.val2 : 32'd0;

  assign res_valid   = res_valid_reg;
  assign res_data    = res_data_reg;
  assign res_br_cond = res_br_cond_reg;
  assign res_tag     = res_tag_reg;

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed testbench for alu_issue_scheduler with a behavioural ALU beside it.
module tb_alu_issue_scheduler;
  import alu_issue_scheduler_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;
  localparam int MUL_LAT = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [NUM_REQ-1:0] req_valid;
  instr_opcode        req_opcode [NUM_REQ];
  logic [31:0]        req_val1   [NUM_REQ];
  logic [31:0]        req_val2   [NUM_REQ];
  logic [TAG_W-1:0]   req_tag    [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  instr_opcode        alu_opcode;
  logic [31:0]        alu_val1, alu_val2, alu_result;
  logic               alu_br_cond;
  logic               res_valid, res_ready, res_br_cond, busy;
  logic [31:0]        res_data;
  logic [TAG_W-1:0]   res_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_scheduler #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_opcode(req_opcode), .req_val1(req_val1),
    .req_val2(req_val2), .req_tag(req_tag), .req_ready(req_ready),
    .alu_opcode(alu_opcode), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_result(alu_result), .alu_br_cond(alu_br_cond),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_br_cond(res_br_cond), .res_tag(res_tag), .busy(busy)
  );

  // Behavioural combinational ALU.
  always_comb begin
    alu_result  = 32'd0;
    alu_br_cond = 1'b0;
    case (alu_opcode)
      ADD_I: alu_result = alu_val1 + alu_val2;
      SUB_I: alu_result = alu_val1 - alu_val2;
      MUL_I: alu_result = alu_val1 * alu_val2;
      BEQ_I: alu_br_cond = (alu_val1 == alu_val2);
      BNE_I: alu_br_cond = (alu_val1 != alu_val2);
      default: ;
    endcase
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] i, input instr_opcode op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
    req_valid[i]  = 1'b1;
    req_opcode[i] = op;
    req_val1[i]   = a;
    req_val2[i]   = b;
    req_tag[i]    = tag;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    res_ready = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_opcode[i] = NOP_I;
      req_val1[i] = '0;
      req_val2[i] = '0;
      req_tag[i] = '0;
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
    checks++; if (res_tag !== 6'd0) begin errors++; $display("FAIL reset_res_tag: got %0d expected 0", res_tag); end
    checks++; if (res_br_cond !== 1'b0) begin errors++; $display("FAIL reset_res_br: got %b expected 0", res_br_cond); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (alu_opcode !== NOP_I || alu_val1 !== 32'd0 || alu_val2 !== 32'd0) begin errors++; $display("FAIL reset_alu: got op=%0d v1=%h v2=%h expected 0", alu_opcode, alu_val1, alu_val2); end
    $display("test_reset: done");
    next_cycle();
  endtask

  task automatic test_single_add();
    set_req(2'd0, ADD_I, 32'd5, 32'd7, 6'd3);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b expected 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || alu_opcode !== ADD_I || alu_val1 !== 32'd5 || alu_val2 !== 32'd7) begin errors++; $display("FAIL add_exec: busy=%b op=%0d v1=%0d v2=%0d expected 1 ADD 5 7", busy, alu_opcode, alu_val1, alu_val2); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b expected 0", res_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd12 || res_tag !== 6'd3 || res_br_cond !== 1'b0) begin errors++; $display("FAIL add_result: valid=%b data=%0d tag=%0d br=%b expected 1 12 3 0", res_valid, res_data, res_tag, res_br_cond); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_drain: valid=%b busy=%b expected 0 0", res_valid, busy); end
    $display("test_single_add: done");
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [1:0] src;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(2'(i), ADD_I, 32'(i), 32'd100, 6'(10 + i));
    end
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req_valid = '0;
      @(negedge clk);
      exp_gnt = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL rr_grant cycle %0d: got %b expected %b", k, req_ready, exp_gnt); end
      if (k >= 2 && k < 10) begin
        src = 2'((k - 2) % 4);
        checks++; if (res_valid !== 1'b1 || res_tag !== 6'(10 + src) || res_data !== 32'(100 + src)) begin errors++; $display("FAIL rr_result cycle %0d: valid=%b tag=%0d data=%0d expected 1 %0d %0d", k, res_valid, res_tag, res_data, 10 + src, 100 + src); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_idle_valid cycle %0d: got %b expected 0", k, res_valid); end
      end
      next_cycle();
    end
    $display("test_round_robin: done");
  endtask

  task automatic test_multiply();
    logic [3:0] exp_gnt;
    set_req(2'd1, MUL_I, 32'hFFFF_FFFD, 32'd4, 6'd5);
    set_req(2'd2, ADD_I, 32'd1, 32'd1, 6'd6);
    for (int k = 0; k < 7; k++) begin
      if (k == 1) req_valid[1] = 1'b0;
      if (k == 4) req_valid[2] = 1'b0;
      @(negedge clk);
      exp_gnt = (k == 0) ? 4'b0010 : (k == 3) ? 4'b0100 : 4'b0000;
      checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL mul_grant cycle %0d: got %b expected %b", k, req_ready, exp_gnt); end
      if (k == 2) begin
        checks++; if (busy !== 1'b1 || alu_opcode !== MUL_I) begin errors++; $display("FAIL mul_busy: busy=%b op=%0d expected 1 MUL", busy, alu_opcode); end
      end
      if (k == 4) begin
        checks++; if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFF4 || res_tag !== 6'd5) begin errors++; $display("FAIL mul_result: valid=%b data=%h tag=%0d expected 1 fffffff4 5", res_valid, res_data, res_tag); end
      end else if (k == 5) begin
        checks++; if (res_valid !== 1'b1 || res_data !== 32'd2 || res_tag !== 6'd6) begin errors++; $display("FAIL mul_follow_add: valid=%b data=%0d tag=%0d expected 1 2 6", res_valid, res_data, res_tag); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mul_valid cycle %0d: got %b expected 0", k, res_valid); end
      end
      next_cycle();
    end
    $display("test_multiply: done");
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_gnt;
    set_req(2'd3, BEQ_I, 32'd9, 32'd9, 6'd20);
    set_req(2'd0, BEQ_I, 32'd9, 32'd9, 6'd21);
    for (int k = 0; k < 11; k++) begin
      if (k == 2) res_ready = 1'b0;
      if (k == 7) res_ready = 1'b1;
      if (k == 8) req_valid = '0;
      @(negedge clk);
      exp_gnt = (k == 0 || k == 7) ? 4'b1000 : (k == 1) ? 4'b0001 : 4'b0000;
      checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL bp_grant cycle %0d: got %b expected %b", k, req_ready, exp_gnt); end
      if (k >= 2 && k <= 7) begin
        checks++; if (res_valid !== 1'b1 || res_br_cond !== 1'b1 || res_tag !== 6'd20 || busy !== 1'b1) begin errors++; $display("FAIL bp_hold cycle %0d: valid=%b br=%b tag=%0d busy=%b expected 1 1 20 1", k, res_valid, res_br_cond, res_tag, busy); end
      end else if (k == 8) begin
        checks++; if (res_valid !== 1'b1 || res_br_cond !== 1'b1 || res_tag !== 6'd21) begin errors++; $display("FAIL bp_resume: valid=%b br=%b tag=%0d expected 1 1 21", res_valid, res_br_cond, res_tag); end
      end else if (k == 9) begin
        checks++; if (res_valid !== 1'b1 || res_tag !== 6'd20) begin errors++; $display("FAIL bp_last: valid=%b tag=%0d expected 1 20", res_valid, res_tag); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_valid cycle %0d: got %b expected 0", k, res_valid); end
      end
      next_cycle();
    end
    $display("test_backpressure: done");
  endtask

  task automatic test_flush();
    logic [3:0] exp_gnt;
    set_req(2'd2, MUL_I, 32'd6, 32'd7, 6'd30);
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin
        req_valid[2] = 1'b0;
        set_req(2'd1, ADD_I, 32'd1, 32'd1, 6'd32);
        set_req(2'd3, ADD_I, 32'd2, 32'd3, 6'd31);
      end
      flush = (k == 3);
      if (k == 5) req_valid = '0;
      @(negedge clk);
      exp_gnt = (k == 0) ? 4'b0100 : (k == 4) ? 4'b1000 : 4'b0000;
      checks++; if (req_ready !== exp_gnt) begin errors++; $display("FAIL flush_grant cycle %0d: got %b expected %b", k, req_ready, exp_gnt); end
      if (k == 4) begin
        checks++; if (busy !== 1'b0 || alu_opcode !== NOP_I) begin errors++; $display("FAIL flush_idle: busy=%b op=%0d expected 0 NOP", busy, alu_opcode); end
      end
      if (k == 6) begin
        checks++; if (res_valid !== 1'b1 || res_tag !== 6'd31 || res_data !== 32'd5) begin errors++; $display("FAIL flush_next_result: valid=%b tag=%0d data=%0d expected 1 31 5", res_valid, res_tag, res_data); end
      end else begin
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_valid cycle %0d: got %b tag=%0d expected 0", k, res_valid, res_tag); end
      end
      next_cycle();
    end
    $display("test_flush: done");
  endtask

  task automatic test_reset_mid();
    set_req(2'd1, ADD_I, 32'd1, 32'd2, 6'd40);
    set_req(2'd2, ADD_I, 32'd3, 32'd4, 6'd41);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant0: got %b expected 0010", req_ready); end
    next_cycle();
    res_ready = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant1: got %b expected 0100", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_tag !== 6'd40 || res_data !== 32'd3 || req_ready !== 4'b0000) begin errors++; $display("FAIL rm_stall: valid=%b tag=%0d data=%0d gnt=%b expected 1 40 3 0000", res_valid, res_tag, res_data, req_ready); end
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      set_req(2'(i), ADD_I, 32'(i + 1), 32'd0, 6'(50 + i));
    end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_rst_grant: got %b expected 0000", req_ready); end
    next_cycle();
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0 || res_data !== 32'd0 || res_tag !== 6'd0 || res_br_cond !== 1'b0) begin errors++; $display("FAIL rm_res_cleared: valid=%b data=%0d tag=%0d br=%b expected all 0", res_valid, res_data, res_tag, res_br_cond); end
    checks++; if (busy !== 1'b0 || alu_opcode !== NOP_I || alu_val1 !== 32'd0 || alu_val2 !== 32'd0) begin errors++; $display("FAIL rm_alu_cleared: busy=%b op=%0d v1=%0d v2=%0d expected all 0", busy, alu_opcode, alu_val1, alu_val2); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_restart_grant: got %b expected 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin errors++; $display("FAIL rm_exec: gnt=%b valid=%b expected 0000 0", req_ready, res_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (res_valid !== 1'b1 || res_tag !== 6'd50 || res_data !== 32'd1) begin errors++; $display("FAIL rm_result: valid=%b tag=%0d data=%0d expected 1 50 1", res_valid, res_tag, res_data); end
    next_cycle();
    $display("test_reset_mid: done");
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    res_ready = 1'b1;
    req_valid = '0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_multiply();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_scheduler.md
# alu_issue_scheduler

Sequences the shared combinational ALU among `NUM_REQ` backend requesters (reservation-station ports) using round-robin arbitration. The block latches one granted operation into an issue register, drives the ALU from it, and holds `MUL_I` for `MUL_LAT` cycles. It captures each result, with its tag and branch condition, into an output register behind a valid/ready handshake toward writeback. It sits between the reservation stations and the common data bus. The ALU is instantiated beside it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2).
- `TAG_W`, 6: destination tag width.
- `MUL_LAT`, 3: total execute cycles for `MUL_I` (≥1).

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `flush`, input, 1: squash all in-flight work.
- `req_valid`, input, `[NUM_REQ]`: request present.
- `req_opcode`, input, `[NUM_REQ]` × `instr_opcode`: request opcode.
- `req_val1` / `req_val2`, input, `[NUM_REQ]` × 32: source operands.
- `req_tag`, input, `[NUM_REQ]` × `TAG_W`: destination tag.
- `req_ready`, output, `[NUM_REQ]`: grant, one-hot or zero.
- `alu_opcode`, output, `instr_opcode`: to ALU `opcode`.
- `alu_val1` / `alu_val2`, output, 32: to ALU operands.
- `alu_result`, input, 32: from ALU `aluout`.
- `alu_br_cond`, input, 1: from ALU `br_cond`.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: writeback accepts.
- `res_data`, output, 32: registered ALU result.
- `res_br_cond`, output, 1: registered branch condition.
- `res_tag`, output, `TAG_W`: registered tag.
- `busy`, output, 1: issue register occupied.

## Operation
- **State machine.** The FSM has three states: `IDLE`, `EXEC`, `MUL_WAIT`.
  - `IDLE`: the issue register is empty.
  - `EXEC`: the ALU evaluates the issue register this cycle.
  - `MUL_WAIT`: a multiply is occupying the ALU.
- **Handshakes.**
  - Output register accept: `out_take = !res_valid | res_ready`.
  - Issue register complete: `iss_done = (EXEC & (op≠MUL_I | MUL_LAT==1) & out_take) | (MUL_WAIT & cnt==0 & out_take)`.
  - Grant permitted: `grant_en = !flush & (IDLE | iss_done)`.
- **Arbitration.**
  - The round-robin pointer `rr_ptr` starts at 0.
  - The winner is the first valid requester at or after `rr_ptr`, searching modulo `NUM_REQ`.
  - `req_ready[winner] = grant_en`; all other bits are 0.
  - On a grant, `rr_ptr ← winner+1` (wraps to 0) and the request fields load into the issue register.
- **Transitions.**
  - On a grant, the next state is `EXEC`.
  - `EXEC` with a non-MUL op (or `MUL_LAT==1`): on `iss_done`, the next state is `EXEC` if a new grant occurred, else `IDLE`. If `!out_take`, the state stays in `EXEC` (stall).
  - `EXEC` with `MUL_I` and `MUL_LAT>1`: the state moves to `MUL_WAIT` with `cnt ← MUL_LAT-2`.
  - `MUL_WAIT`: `cnt` decrements each cycle while >0. At 0, the state waits for `out_take`, then completes.
- **Result capture.** On `iss_done`:
  - `res_data ← alu_result`.
  - `res_br_cond ← alu_br_cond`. The ALU already returns 0 for non-branch ops.
  - `res_tag ← issue tag`; `res_valid ← 1`.
  - Otherwise, `res_valid` clears when `res_ready` is high.
- **ALU drive.** `alu_opcode`, `alu_val1` and `alu_val2` come directly from the issue register. When idle they are driven to zero, which gives ALU default output 0.
- **Flush.** Priority is `rst` > `flush` > normal operation.
  - State ← `IDLE`; `res_valid` ← 0; `cnt` ← 0.
  - No grant is issued in the flush cycle.
  - `rr_ptr` is held.
- **Widths.**
  - The multiply result is the low 32 bits only.
  - `cnt` is `$clog2(MUL_LAT)` bits, with a minimum of 1.
  - `rr_ptr` is `$clog2(NUM_REQ)` bits.

## Timing
- **Reset values.** `req_ready`=0, `res_valid`=0, `res_data`=0, `res_br_cond`=0, `res_tag`=0, `busy`=0, `alu_*`=0, state `IDLE`, `rr_ptr`=0.
- **Single-cycle op latency.** Grant in cycle N → ALU evaluates in N+1 → `res_valid` high in N+2.
- **Multiply latency.** Grant in cycle N → `res_valid` high in N+1+`MUL_LAT`.
- **Throughput.** Non-MUL ops sustain one per cycle while `res_ready`=1.
- **Backpressure.** `res_valid`=1 with `res_ready`=0 freezes the output register and the issue register. `req_ready` stays 0.
- **Simultaneous grant and complete.** These are allowed in the same cycle, with no bubble.
- **Request stability.** Requesters must hold their request until granted.

## Structure
- **Shared backend package.** Holds `instr_opcode` (existing) and a new `alu_issue_t` struct with fields `{opcode, val1, val2, tag}`.
- **Sub-module `rr_arbiter`.** Parameter `N`. Inputs: `req`, `en`. Outputs: one-hot `gnt`. Holds its pointer internally and updates on `en & |req`.

## Test plan
- **Single ADD.** Requester 0 `ADD_I`, 5 and 7, tag 3, at cycle 1 → `res_valid` at cycle 3 with `res_data`=12, `res_tag`=3, `res_br_cond`=0.
- **Round-robin fairness.** All four requesters hold valid continuously → grants go 0,1,2,3,0, each exactly once per 4 cycles.
- **Multiply latency.** With `MUL_LAT`=3: `MUL_I` −3 × 4 → `res_data`=0xFFFFFFF4 exactly 4 cycles after grant. A following `ADD_I` is not granted until the cycle the MUL completes.
- **Backpressure.** `res_ready`=0 for 5 cycles during a `BEQ_I` 9,9 stream → `res_valid`, `res_br_cond`=1 and `res_tag` held; `req_ready`=0. Completion resumes the cycle after `res_ready` rises.
- **Flush mid-multiply.** `flush` in `MUL_WAIT` → next cycle state `IDLE`, `res_valid`=0, no result for that tag ever appears. The next grant follows `rr_ptr` unchanged.
- **Reset mid-operation.** `rst` during a valid stall → all outputs return to reset values next cycle, and the grant order restarts from requester 0.
